// File: rtl/wb_gpio_irq_ctrl.sv
// Wishbone GPIO controller: pad out/oeb registers, synchronised inputs and
// per-pin edge interrupts folded onto IRQ_LINES level outputs.

module wb_gpio_pin #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  input  logic edge_sel,
  output logic sync_q,
  output logic hit
);
  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pad};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync_q = chain[SYNC_STAGES-1];
  // Only a real transition qualifies, so flipping edge_sel never fakes an edge.
  assign hit = edge_sel ? (sync_q & ~prev) : (~sync_q & prev);
endmodule

module wb_gpio_irq_ctrl #(
  parameter int          NUM_IO      = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          SYNC_STAGES = 2,
  parameter int          IRQ_LINES   = 3
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  input  logic [NUM_IO-1:0]    io_in,
  output logic [NUM_IO-1:0]    io_out,
  output logic [NUM_IO-1:0]    io_oeb,
  output logic [IRQ_LINES-1:0] user_irq
);
  localparam logic [7:0] OFF_OUT  = 8'h00;
  localparam logic [7:0] OFF_OEB  = 8'h04;
  localparam logic [7:0] OFF_IN   = 8'h08;
  localparam logic [7:0] OFF_EN   = 8'h0C;
  localparam logic [7:0] OFF_EDGE = 8'h10;
  localparam logic [7:0] OFF_STAT = 8'h14;
  localparam logic [7:0] OFF_PEND = 8'h18;

  logic [NUM_IO-1:0]    out_r, oeb_r, en_r, edge_r, stat_r;
  logic [NUM_IO-1:0]    in_w, hit_w, pend_w, wm, wd, clr;
  logic [31:0]          bmask, rdata;
  logic [IRQ_LINES-1:0] irq_next;
  logic                 req, wr;
  logic [7:0]           off;

  for (genvar g = 0; g < NUM_IO; g++) begin : g_pin
    wb_gpio_pin #(.SYNC_STAGES(SYNC_STAGES)) u_pin (
      .clk      (wb_clk_i),
      .rst      (wb_rst_i),
      .pad      (io_in[g]),
      .edge_sel (edge_r[g]),
      .sync_q   (in_w[g]),
      .hit      (hit_w[g])
    );
  end

  assign off    = wbs_adr_i[7:0];
  assign req    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~wbs_ack_o;
  assign wr     = req & wbs_we_i;
  assign bmask  = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign wm     = bmask[NUM_IO-1:0];
  assign wd     = wbs_dat_i[NUM_IO-1:0];
  assign pend_w = stat_r & en_r;
  assign clr    = (wr && off == OFF_STAT) ? (wd & wm) : '0;

  always_comb begin
    rdata = '0;
    case (off)
      OFF_OUT:  rdata = 32'(out_r);
      OFF_OEB:  rdata = 32'(oeb_r);
      OFF_IN:   rdata = 32'(in_w);
      OFF_EN:   rdata = 32'(en_r);
      OFF_EDGE: rdata = 32'(edge_r);
      OFF_STAT: rdata = 32'(stat_r);
      OFF_PEND: rdata = 32'(pend_w);
      default:  rdata = '0;
    endcase
  end

  always_comb begin
    irq_next = '0;
    for (int i = 0; i < NUM_IO; i++)
      if (pend_w[i]) irq_next[i % IRQ_LINES] = 1'b1;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      out_r     <= '0;
      oeb_r     <= '1;
      en_r      <= '0;
      edge_r    <= '0;
      stat_r    <= '0;
      user_irq  <= '0;
    end else begin
      wbs_ack_o <= req;
      if (req) wbs_dat_o <= rdata;
      if (wr) begin
        case (off)
          OFF_OUT:  out_r  <= (out_r  & ~wm) | (wd & wm);
          OFF_OEB:  oeb_r  <= (oeb_r  & ~wm) | (wd & wm);
          OFF_EN:   en_r   <= (en_r   & ~wm) | (wd & wm);
          OFF_EDGE: edge_r <= (edge_r & ~wm) | (wd & wm);
          default:  ;
        endcase
      end
      // New edge ORed in after the clear so a same-cycle edge survives W1C.
      stat_r   <= (stat_r & ~clr) | hit_w;
      user_irq <= irq_next;
    end
  end

  assign io_out = out_r;
  assign io_oeb = oeb_r;
endmodule

// File: tb/tb_wb_gpio_irq_ctrl.sv
// Directed bench for wb_gpio_irq_ctrl: register table plus handshake, IRQ,
// collision and async-reset sequences.

module tb_wb_gpio_irq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, dat = '0;
  logic        ack;
  logic [31:0] dat_o;
  logic [31:0] io_in = '0;
  logic [31:0] io_out, io_oeb;
  logic [2:0]  user_irq;

  int n_chk = 0;
  int n_fail = 0;

  wb_gpio_irq_ctrl dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .user_irq  (user_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One single-cycle transaction; inputs change on negedges, ack sampled on the next.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    @(negedge clk);
    chk("bus_ack", {31'd0, ack}, 32'd1);
    rd = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_rd;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vt[16];
  logic [31:0] rd;
  logic        seen_ack;
  logic [3:0]  ack_pat;

  initial begin
    vt[0]  = '{1'b0, 32'h3000_0004, 32'h0,         4'hF, 32'hFFFF_FFFF, 32'h0};
    vt[1]  = '{1'b1, 32'h3000_0000, 32'hA5A5_5A5A, 4'h3, 32'h0,         32'h0000_5A5A};
    vt[2]  = '{1'b0, 32'h3000_0000, 32'h0,         4'hF, 32'h0000_5A5A, 32'h0000_5A5A};
    vt[3]  = '{1'b1, 32'h3000_0000, 32'hFFFF_FFFF, 4'h0, 32'h0,         32'h0000_5A5A};
    vt[4]  = '{1'b0, 32'h3000_0000, 32'h0,         4'hF, 32'h0000_5A5A, 32'h0000_5A5A};
    vt[5]  = '{1'b1, 32'h3000_0004, 32'h1234_0000, 4'h4, 32'h0,         32'h0000_5A5A};
    vt[6]  = '{1'b0, 32'h3000_0004, 32'h0,         4'hF, 32'hFF34_FFFF, 32'h0000_5A5A};
    vt[7]  = '{1'b1, 32'h3000_0008, 32'hFFFF_FFFF, 4'hF, 32'h0,         32'h0000_5A5A};
    vt[8]  = '{1'b0, 32'h3000_0008, 32'h0,         4'hF, 32'h0,         32'h0000_5A5A};
    vt[9]  = '{1'b1, 32'h3000_0018, 32'hFFFF_FFFF, 4'hF, 32'h0,         32'h0000_5A5A};
    vt[10] = '{1'b0, 32'h3000_0018, 32'h0,         4'hF, 32'h0,         32'h0000_5A5A};
    vt[11] = '{1'b0, 32'h3000_0040, 32'h0,         4'hF, 32'h0,         32'h0000_5A5A};
    vt[12] = '{1'b1, 32'h3000_0010, 32'h0000_0010, 4'hF, 32'h0,         32'h0000_5A5A};
    vt[13] = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, 32'h0000_0010, 32'h0000_5A5A};
    vt[14] = '{1'b1, 32'h3000_000C, 32'h0000_0010, 4'hF, 32'h0,         32'h0000_5A5A};
    vt[15] = '{1'b0, 32'h3000_000C, 32'h0,         4'hF, 32'h0000_0010, 32'h0000_5A5A};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_oeb", io_oeb, 32'hFFFF_FFFF);
    chk("rst_out", io_out, 32'h0);
    chk("rst_irq", {29'd0, user_irq}, 32'h0);
    chk("rst_ack", {31'd0, ack}, 32'h0);
    chk("rst_dat", dat_o, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      bus(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, rd);
      if (!vt[i].we) chk($sformatf("vec%0d_rd", i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_out", i), io_out, vt[i].exp_out);
    end

    // Held strobe: ack every other cycle
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0000; sel = 4'hF;
    ack_pat[3] = ack;
    for (int i = 2; i >= 0; i--) begin
      @(negedge clk);
      ack_pat[i] = ack;
    end
    cyc = 1'b0; stb = 1'b0;
    chk("held_ack_pat", {28'd0, ack_pat}, 32'h5);

    // Outside the window: never acked, nothing written
    @(negedge clk);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0100; dat = 32'hFFFF_FFFF; sel = 4'hF;
    seen_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen_ack |= ack;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("oow_no_ack", {31'd0, seen_ack}, 32'h0);
    chk("oow_out", io_out, 32'h0000_5A5A);

    // Rising edge on pin 4 -> IRQ line 1
    @(negedge clk);
    io_in[4] = 1'b1;
    repeat (3) @(negedge clk);
    chk("rise_irq_p3", {29'd0, user_irq}, 32'h0);
    @(negedge clk);
    chk("rise_irq_p4", {29'd0, user_irq}, 32'h2);
    bus(1'b0, 32'h3000_0008, 32'h0, 4'hF, rd);
    chk("rise_in", rd, 32'h0000_0010);
    bus(1'b0, 32'h3000_0014, 32'h0, 4'hF, rd);
    chk("rise_stat", rd, 32'h0000_0010);
    bus(1'b1, 32'h3000_0014, 32'h0000_0010, 4'hF, rd);
    chk("w1c_irq_ack", {29'd0, user_irq}, 32'h2);
    @(negedge clk);
    chk("w1c_irq_drop", {29'd0, user_irq}, 32'h0);

    // Falling edge on pin 4 is ignored; then W1C collides with a new rising edge
    io_in[4] = 1'b0;
    repeat (5) @(negedge clk);
    io_in[4] = 1'b1;
    @(negedge clk);
    bus(1'b1, 32'h3000_0014, 32'h0000_0010, 4'hF, rd);
    bus(1'b0, 32'h3000_0014, 32'h0, 4'hF, rd);
    chk("collide_stat", rd, 32'h0000_0010);
    chk("collide_irq", {29'd0, user_irq}, 32'h2);
    bus(1'b1, 32'h3000_0014, 32'h0000_0010, 4'hF, rd);
    repeat (2) @(negedge clk);
    chk("clr2_irq", {29'd0, user_irq}, 32'h0);

    // Falling edge on masked pin 7, then enable it
    io_in[7] = 1'b1;
    repeat (5) @(negedge clk);
    io_in[7] = 1'b0;
    repeat (5) @(negedge clk);
    bus(1'b0, 32'h3000_0014, 32'h0, 4'hF, rd);
    chk("fall_stat", rd, 32'h0000_0080);
    bus(1'b0, 32'h3000_0018, 32'h0, 4'hF, rd);
    chk("fall_pend", rd, 32'h0);
    chk("fall_irq_masked", {29'd0, user_irq}, 32'h0);
    bus(1'b1, 32'h3000_000C, 32'h0000_0090, 4'hF, rd);
    chk("en7_irq_ack", {29'd0, user_irq}, 32'h0);
    @(negedge clk);
    chk("en7_irq_next", {29'd0, user_irq}, 32'h2);
    bus(1'b0, 32'h3000_0018, 32'h0, 4'hF, rd);
    chk("en7_pend", rd, 32'h0000_0080);

    // Reset during the ack cycle of a write to OUT
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0000; dat = 32'h1234_5678; sel = 4'hF;
    @(posedge clk);
    #1;
    chk("ar_ack_hi", {31'd0, ack}, 32'h1);
    rst = 1'b1;
    #1;
    chk("ar_ack_drop", {31'd0, ack}, 32'h0);
    chk("ar_out", io_out, 32'h0);
    chk("ar_irq", {29'd0, user_irq}, 32'h0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst = 1'b0;
    io_in = '0;
    repeat (3) @(negedge clk);
    chk("ar_post_out", io_out, 32'h0);
    chk("ar_post_oeb", io_oeb, 32'hFFFF_FFFF);
    bus(1'b0, 32'h3000_0000, 32'h0, 4'hF, rd);
    chk("ar_post_rd", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
